// File: rtl/channel_read_pkg.sv
// Shared types, constants and helpers for the channel read-side detector.
package channel_read_pkg;

   // Threshold voltages are unsigned Q4.12: 4 integer bits, 12 fractional bits
   // (1 LSB = 1/4096 V).
   localparam int VOLT_W = 16;

   // Default read references: 2.20 V, 2.85 V, 3.45 V.
   localparam logic [VOLT_W-1:0] THR1_DEFAULT = 16'h2333;
   localparam logic [VOLT_W-1:0] THR2_DEFAULT = 16'h2D9A;
   localparam logic [VOLT_W-1:0] THR3_DEFAULT = 16'h3733;

   // Map a voltage-ordered level index onto the channel's Gray-coded level.
   function automatic logic [1:0] gray_of_index(input logic [1:0] idx);
      case (idx)
         2'd0:    return 2'b11;
         2'd1:    return 2'b10;
         2'd2:    return 2'b00;
         default: return 2'b01;
      endcase
   endfunction

   // Number of set bits in a 2-bit value (0..2).
   function automatic logic [1:0] popcount2(input logic [1:0] v);
      return {1'b0, v[1]} + {1'b0, v[0]};
   endfunction

   // 32-bit accumulate that sticks at all-ones instead of wrapping.
   function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [1:0] inc);
      logic [32:0] sum;
      sum = {1'b0, a} + {31'b0, inc};
      return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
   endfunction

endpackage

// File: rtl/channel_read_detector_if.sv
// Bus bundle between the channel model / host (master) and the read detector (slave).
interface channel_read_detector_if;
   import channel_read_pkg::*;

   logic              WriteValid;
   logic [1:0]        WriteLevel;
   logic              ReadValid;
   logic [VOLT_W-1:0] ReadVoltage;
   logic              Clear;

   logic              DetectedValid;
   logic [1:0]        DetectedLevel;
   logic [31:0]       CellCount;
   logic [31:0]       BitErrorCount;
   logic [31:0]       SymbolErrorCount;
   logic              PageDone;
   logic [15:0]       PageBitErrors;
   logic              FifoOverflow;
   logic              FifoUnderflow;

   modport master (
      output WriteValid, WriteLevel, ReadValid, ReadVoltage, Clear,
      input  DetectedValid, DetectedLevel, CellCount, BitErrorCount,
             SymbolErrorCount, PageDone, PageBitErrors, FifoOverflow, FifoUnderflow
   );

   modport slave (
      input  WriteValid, WriteLevel, ReadValid, ReadVoltage, Clear,
      output DetectedValid, DetectedLevel, CellCount, BitErrorCount,
             SymbolErrorCount, PageDone, PageBitErrors, FifoOverflow, FifoUnderflow
   );

endinterface

// File: rtl/level_ref_fifo.sv
// Written-level FIFO. A pop frees its slot in the same cycle, so a push to a
// full FIFO alongside a pop is accepted; an empty FIFO never bypasses a push
// straight to the read port. Read data is registered on pop.
module level_ref_fifo #(
   parameter int DEPTH = 64,
   parameter int WIDTH = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [WIDTH-1:0] rd_data_q;
   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic             push, pop;

   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign pop   = rd_en && !empty;
   assign push  = wr_en && (!full || pop);
   assign rd_data = rd_data_q;

   // Pointer advance for accepted push/pop.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push) wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
      if (pop)  rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
   end

   // Pointer registers; reset empties the FIFO.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage with registered read; a same-slot push/pop returns the old entry.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr_q[AW-1:0]] <= wr_data;
      if (pop)  rd_data_q <= mem[rd_ptr_q[AW-1:0]];
   end

endmodule

// File: rtl/channel_read_detector.sv
// Hard-decision read detector: slices the retention Vth stream into 2-bit
// Gray levels, compares each against the level written into the channel and
// accumulates bit / symbol / per-page error statistics.
module channel_read_detector
   import channel_read_pkg::*;
#(
   parameter int                FIFO_DEPTH = 64,
   parameter int                PAGE_CELLS = 16,
   parameter logic [VOLT_W-1:0] THR1       = THR1_DEFAULT,
   parameter logic [VOLT_W-1:0] THR2       = THR2_DEFAULT,
   parameter logic [VOLT_W-1:0] THR3       = THR3_DEFAULT
) (
   input  logic                   clk,
   input  logic                   reset,
   channel_read_detector_if.slave bus
);

   localparam int PCW = (PAGE_CELLS > 1) ? $clog2(PAGE_CELLS) : 1;
   localparam logic [PCW-1:0] PAGE_LAST = PCW'(PAGE_CELLS - 1);

   logic [1:0]  ref_level;
   logic        fifo_full, fifo_empty;
   logic        read_underflow, write_overflow;

   // Stage 1: detection result, popped reference (inside the FIFO) and underflow tag.
   logic        det_valid_q, det_valid_d;
   logic [1:0]  det_level_q, det_level_d;
   logic        uf_tag_q, uf_tag_d;
   logic        ovf_q, ovf_d;
   logic        unf_q, unf_d;

   // Stage 2: statistics.
   logic [31:0]    cell_q, cell_d;
   logic [31:0]    bit_q, bit_d;
   logic [31:0]    sym_q, sym_d;
   logic [PCW-1:0] page_cnt_q, page_cnt_d;
   logic [15:0]    page_acc_q, page_acc_d;
   logic [15:0]    page_bits_q, page_bits_d;
   logic           page_done_q, page_done_d;
   logic [1:0]     err_bits;
   logic [15:0]    page_sum;

   level_ref_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(2)) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (bus.WriteValid),
      .wr_data (bus.WriteLevel),
      .rd_en   (bus.ReadValid),
      .rd_data (ref_level),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   assign read_underflow = bus.ReadValid && fifo_empty;
   // A full FIFO only drops the write if no pop frees a slot this cycle.
   assign write_overflow = bus.WriteValid && fifo_full && !(bus.ReadValid && !fifo_empty);

   // Stage-1 next state: threshold slicing (ties go up) and sticky FIFO flags.
   always_comb begin
      det_valid_d = bus.ReadValid;
      uf_tag_d    = read_underflow;
      det_level_d = det_level_q;
      if (bus.ReadValid) begin
         if (bus.ReadVoltage < THR1)      det_level_d = gray_of_index(2'd0);
         else if (bus.ReadVoltage < THR2) det_level_d = gray_of_index(2'd1);
         else if (bus.ReadVoltage < THR3) det_level_d = gray_of_index(2'd2);
         else                             det_level_d = gray_of_index(2'd3);
      end
      ovf_d = ovf_q || write_overflow;
      unf_d = unf_q || read_underflow;
      if (bus.Clear) begin
         ovf_d = 1'b0;
         unf_d = 1'b0;
      end
   end

   // Stage-2 next state: error accumulation, page tracking, Clear overrides.
   always_comb begin
      cell_d      = cell_q;
      bit_d       = bit_q;
      sym_d       = sym_q;
      page_cnt_d  = page_cnt_q;
      page_acc_d  = page_acc_q;
      page_bits_d = page_bits_q;
      page_done_d = 1'b0;
      err_bits    = popcount2(det_level_q ^ ref_level);
      page_sum    = page_acc_q + {14'b0, err_bits};
      if (det_valid_q && !uf_tag_q) begin
         cell_d = sat_add32(cell_q, 2'd1);
         bit_d  = sat_add32(bit_q, err_bits);
         sym_d  = sat_add32(sym_q, {1'b0, (err_bits != 2'd0)});
         if (page_cnt_q == PAGE_LAST) begin
            page_done_d = 1'b1;
            page_bits_d = page_sum;
            page_acc_d  = '0;
            page_cnt_d  = '0;
         end else begin
            page_acc_d  = page_sum;
            page_cnt_d  = page_cnt_q + {{(PCW-1){1'b0}}, 1'b1};
         end
      end
      if (bus.Clear) begin
         cell_d      = '0;
         bit_d       = '0;
         sym_d       = '0;
         page_cnt_d  = '0;
         page_acc_d  = '0;
         page_bits_d = '0;
         page_done_d = 1'b0;
      end
   end

   // Pipeline and statistics registers; reset drops in-flight stages.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         det_valid_q <= 1'b0;
         det_level_q <= '0;
         uf_tag_q    <= 1'b0;
         ovf_q       <= 1'b0;
         unf_q       <= 1'b0;
         cell_q      <= '0;
         bit_q       <= '0;
         sym_q       <= '0;
         page_cnt_q  <= '0;
         page_acc_q  <= '0;
         page_bits_q <= '0;
         page_done_q <= 1'b0;
      end else begin
         det_valid_q <= det_valid_d;
         det_level_q <= det_level_d;
         uf_tag_q    <= uf_tag_d;
         ovf_q       <= ovf_d;
         unf_q       <= unf_d;
         cell_q      <= cell_d;
         bit_q       <= bit_d;
         sym_q       <= sym_d;
         page_cnt_q  <= page_cnt_d;
         page_acc_q  <= page_acc_d;
         page_bits_q <= page_bits_d;
         page_done_q <= page_done_d;
      end
   end

   assign bus.DetectedValid    = det_valid_q;
   assign bus.DetectedLevel    = det_level_q;
   assign bus.CellCount        = cell_q;
   assign bus.BitErrorCount    = bit_q;
   assign bus.SymbolErrorCount = sym_q;
   assign bus.PageDone         = page_done_q;
   assign bus.PageBitErrors    = page_bits_q;
   assign bus.FifoOverflow     = ovf_q;
   assign bus.FifoUnderflow    = unf_q;

endmodule

// File: tb/tb_channel_read_detector.sv
// Self-checking bench for channel_read_detector: directed scenarios plus a
// randomized stream, all checked every cycle against a queue-based model.
module tb_channel_read_detector;
   import channel_read_pkg::*;

   localparam int DEPTH = 64;
   localparam int PAGE  = 16;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   channel_read_detector_if bus();

   channel_read_detector #(
      .FIFO_DEPTH (DEPTH),
      .PAGE_CELLS (PAGE),
      .THR1       (16'h2333),
      .THR2       (16'h2D9A),
      .THR3       (16'h3733)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model state: written levels in flight and the statistics the
   // DUT should present after the most recent clock edge.
   logic [1:0]  wq[$];
   longint      m_cell, m_bit, m_sym;
   int          m_pcnt, m_pacc, m_pbits;
   bit          m_done, m_ovf, m_unf;
   bit          pend_valid;
   int          pend_bits;

   // Hard decision: count of thresholds at or below v selects the level.
   function automatic logic [1:0] ref_detect(input logic [15:0] v);
      logic [1:0] lut [4];
      int idx;
      lut[0] = 2'b11; lut[1] = 2'b10; lut[2] = 2'b00; lut[3] = 2'b01;
      idx = int'(v >= 16'h2333) + int'(v >= 16'h2D9A) + int'(v >= 16'h3733);
      return lut[idx];
   endfunction

   function automatic int bit_diff(input logic [1:0] a, input logic [1:0] b);
      int n = 0;
      for (int i = 0; i < 2; i++) if (a[i] != b[i]) n++;
      return n;
   endfunction

   // A voltage inside the decision region of a given Gray level.
   function automatic logic [15:0] volt_for(input logic [1:0] lvl);
      case (lvl)
         2'b11:   return 16'h119A;
         2'b10:   return 16'h28CD;
         2'b00:   return 16'h3266;
         default: return 16'h3C00;
      endcase
   endfunction

   function automatic longint sat32(input longint x);
      return (x > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : x;
   endfunction

   task automatic model_zero();
      m_cell = 0; m_bit = 0; m_sym = 0;
      m_pcnt = 0; m_pacc = 0; m_pbits = 0;
      m_done = 0; m_ovf = 0; m_unf = 0;
      pend_valid = 0; pend_bits = 0;
   endtask

   // One clock of traffic: drive, advance the model, clock, compare all outputs.
   task automatic step(input logic wv, input logic [1:0] wl, input logic rv,
                       input logic [15:0] v, input logic clr);
      logic [1:0] exp_level;
      logic [1:0] r;
      bus.WriteValid  = wv;
      bus.WriteLevel  = wl;
      bus.ReadValid   = rv;
      bus.ReadVoltage = v;
      bus.Clear       = clr;

      // Statistics for the read of the previous cycle land on this edge.
      if (clr) begin
         model_zero();
      end else begin
         m_done = 0;
         if (pend_valid) begin
            m_cell = sat32(m_cell + 1);
            m_bit  = sat32(m_bit + pend_bits);
            m_sym  = sat32(m_sym + ((pend_bits != 0) ? 1 : 0));
            m_pacc += pend_bits;
            m_pcnt++;
            if (m_pcnt == PAGE) begin
               m_done = 1; m_pbits = m_pacc; m_pacc = 0; m_pcnt = 0;
            end
         end
      end
      pend_valid = 0;
      exp_level = 2'b00;
      // The read sees the FIFO before this cycle's write lands.
      if (rv) begin
         exp_level = ref_detect(v);
         if (wq.size() > 0) begin
            r = wq.pop_front();
            pend_valid = 1;
            pend_bits = bit_diff(exp_level, r);
         end else if (!clr) begin
            m_unf = 1;
         end
      end
      if (wv) begin
         if (wq.size() < DEPTH) wq.push_back(wl);
         else if (!clr) m_ovf = 1;
      end

      @(posedge clk); #1;

      n_cmp++;
      if (bus.DetectedValid !== rv) begin
         n_bad++; $display("FAIL det_valid: got %b expected %b", bus.DetectedValid, rv);
      end
      if (rv) begin
         n_cmp++;
         if (bus.DetectedLevel !== exp_level) begin
            n_bad++; $display("FAIL det_level: got %b expected %b (v=%h)", bus.DetectedLevel, exp_level, v);
         end
      end
      n_cmp++;
      if (bus.CellCount !== 32'(m_cell)) begin
         n_bad++; $display("FAIL cell_count: got %0d expected %0d", bus.CellCount, m_cell);
      end
      n_cmp++;
      if (bus.BitErrorCount !== 32'(m_bit)) begin
         n_bad++; $display("FAIL bit_errors: got %0d expected %0d", bus.BitErrorCount, m_bit);
      end
      n_cmp++;
      if (bus.SymbolErrorCount !== 32'(m_sym)) begin
         n_bad++; $display("FAIL sym_errors: got %0d expected %0d", bus.SymbolErrorCount, m_sym);
      end
      n_cmp++;
      if (bus.PageDone !== m_done) begin
         n_bad++; $display("FAIL page_done: got %b expected %b", bus.PageDone, m_done);
      end
      n_cmp++;
      if (bus.PageBitErrors !== 16'(m_pbits)) begin
         n_bad++; $display("FAIL page_bits: got %0d expected %0d", bus.PageBitErrors, m_pbits);
      end
      n_cmp++;
      if (bus.FifoOverflow !== m_ovf) begin
         n_bad++; $display("FAIL overflow: got %b expected %b", bus.FifoOverflow, m_ovf);
      end
      n_cmp++;
      if (bus.FifoUnderflow !== m_unf) begin
         n_bad++; $display("FAIL underflow: got %b expected %b", bus.FifoUnderflow, m_unf);
      end
      $display("[%0t] wv=%b wl=%b rv=%b v=%h clr=%b -> dv=%b dl=%b cells=%0d bits=%0d syms=%0d pd=%b pbe=%0d ovf=%b unf=%b",
               $time, wv, wl, rv, v, clr, bus.DetectedValid, bus.DetectedLevel, bus.CellCount,
               bus.BitErrorCount, bus.SymbolErrorCount, bus.PageDone, bus.PageBitErrors,
               bus.FifoOverflow, bus.FifoUnderflow);
      bus.WriteValid = 1'b0;
      bus.ReadValid  = 1'b0;
      bus.Clear      = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 2'b00, 1'b0, 16'h0, 1'b0);
   endtask

   task automatic do_clear();
      idle(2);
      step(1'b0, 2'b00, 1'b0, 16'h0, 1'b1);
   endtask

   task automatic check_outputs_zero(input string tag);
      n_cmp++;
      if ({bus.DetectedValid, bus.DetectedLevel, bus.CellCount, bus.BitErrorCount,
           bus.SymbolErrorCount, bus.PageDone, bus.PageBitErrors,
           bus.FifoOverflow, bus.FifoUnderflow} !== '0) begin
         n_bad++;
         $display("FAIL %s: outputs not zero (cells=%0d bits=%0d syms=%0d dv=%b dl=%b pd=%b pbe=%0d ovf=%b unf=%b) expected all 0",
                  tag, bus.CellCount, bus.BitErrorCount, bus.SymbolErrorCount, bus.DetectedValid,
                  bus.DetectedLevel, bus.PageDone, bus.PageBitErrors, bus.FifoOverflow, bus.FifoUnderflow);
      end
   endtask

   // Reset is asserted away from the clock edge; outputs must clear at once.
   task automatic apply_reset();
      reset = 1'b1;
      #2;
      check_outputs_zero("reset_async");
      wq.delete();
      model_zero();
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      $display("[%0t] reset released", $time);
   endtask

   task automatic test_reset();
      bus.WriteValid = 1'b0; bus.WriteLevel = 2'b00; bus.ReadValid = 1'b0;
      bus.ReadVoltage = '0;  bus.Clear = 1'b0;
      apply_reset();
      check_outputs_zero("reset_state");
      idle(2);
   endtask

   task automatic test_basic();
      logic [1:0] lv [4];
      lv[0] = 2'b11; lv[1] = 2'b10; lv[2] = 2'b00; lv[3] = 2'b01;
      do_clear();
      for (int i = 0; i < 4; i++) step(1'b1, lv[i], 1'b0, 16'h0, 1'b0);
      for (int i = 0; i < 4; i++) step(1'b0, 2'b00, 1'b1, volt_for(lv[i]), 1'b0);
      idle(2);
      n_cmp++;
      if (bus.CellCount !== 32'd4) begin
         n_bad++; $display("FAIL basic_cells: got %0d expected 4", bus.CellCount);
      end
      n_cmp++;
      if (bus.BitErrorCount !== 32'd0) begin
         n_bad++; $display("FAIL basic_bits: got %0d expected 0", bus.BitErrorCount);
      end
   endtask

   task automatic test_boundary();
      do_clear();
      step(1'b1, 2'b11, 1'b0, 16'h0, 1'b0);
      step(1'b1, 2'b11, 1'b0, 16'h0, 1'b0);
      step(1'b0, 2'b00, 1'b1, 16'h2333, 1'b0);
      n_cmp++;
      if (bus.DetectedLevel !== 2'b10) begin
         n_bad++; $display("FAIL boundary_eq: got %b expected 10", bus.DetectedLevel);
      end
      step(1'b0, 2'b00, 1'b1, 16'h2332, 1'b0);
      n_cmp++;
      if (bus.DetectedLevel !== 2'b11) begin
         n_bad++; $display("FAIL boundary_below: got %b expected 11", bus.DetectedLevel);
      end
      idle(2);
      n_cmp++;
      if (bus.BitErrorCount !== 32'd1 || bus.SymbolErrorCount !== 32'd1) begin
         n_bad++; $display("FAIL boundary_totals: got bits=%0d syms=%0d expected 1/1",
                           bus.BitErrorCount, bus.SymbolErrorCount);
      end
   endtask

   task automatic test_errors();
      do_clear();
      step(1'b1, 2'b01, 1'b0, 16'h0, 1'b0);
      step(1'b1, 2'b10, 1'b0, 16'h0, 1'b0);
      step(1'b0, 2'b00, 1'b1, 16'h119A, 1'b0);
      step(1'b0, 2'b00, 1'b1, 16'h3C00, 1'b0);
      idle(2);
      n_cmp++;
      if (bus.BitErrorCount !== 32'd3 || bus.SymbolErrorCount !== 32'd2) begin
         n_bad++; $display("FAIL error_totals: got bits=%0d syms=%0d expected 3/2",
                           bus.BitErrorCount, bus.SymbolErrorCount);
      end
   endtask

   // Full page with 3 single-bit errors, then a second page with one.
   task automatic test_page();
      do_clear();
      for (int i = 0; i < 2 * PAGE; i++) step(1'b1, 2'b11, 1'b0, 16'h0, 1'b0);
      for (int i = 0; i < PAGE; i++)
         step(1'b0, 2'b00, 1'b1, (i == 2 || i == 7 || i == 15) ? 16'h28CD : 16'h119A, 1'b0);
      n_cmp++;
      if (bus.PageDone !== 1'b0) begin
         n_bad++; $display("FAIL page_early: got %b expected 0", bus.PageDone);
      end
      idle(1);
      n_cmp++;
      if (bus.PageDone !== 1'b1 || bus.PageBitErrors !== 16'd3) begin
         n_bad++; $display("FAIL page1: got done=%b bits=%0d expected 1/3", bus.PageDone, bus.PageBitErrors);
      end
      idle(1);
      n_cmp++;
      if (bus.PageDone !== 1'b0) begin
         n_bad++; $display("FAIL page_pulse: got %b expected 0", bus.PageDone);
      end
      for (int i = 0; i < PAGE; i++)
         step(1'b0, 2'b00, 1'b1, (i == 9) ? 16'h28CD : 16'h119A, 1'b0);
      idle(1);
      n_cmp++;
      if (bus.PageDone !== 1'b1 || bus.PageBitErrors !== 16'd1) begin
         n_bad++; $display("FAIL page2: got done=%b bits=%0d expected 1/1", bus.PageDone, bus.PageBitErrors);
      end
   endtask

   task automatic test_overflow_underflow();
      while (wq.size() > 0) step(1'b0, 2'b00, 1'b1, 16'h119A, 1'b0);
      do_clear();
      for (int i = 0; i < DEPTH + 1; i++) step(1'b1, 2'(i), 1'b0, 16'h0, 1'b0);
      n_cmp++;
      if (bus.FifoOverflow !== 1'b1) begin
         n_bad++; $display("FAIL overflow_set: got %b expected 1", bus.FifoOverflow);
      end
      for (int i = 0; i < DEPTH + 1; i++)
         step(1'b0, 2'b00, 1'b1, 16'(($urandom_range(0, 3) * 16'h1000) + 16'h0800), 1'b0);
      idle(2);
      n_cmp++;
      if (bus.FifoUnderflow !== 1'b1 || bus.CellCount !== 32'd64) begin
         n_bad++; $display("FAIL underflow_set: got unf=%b cells=%0d expected 1/64",
                           bus.FifoUnderflow, bus.CellCount);
      end
      do_clear();
      n_cmp++;
      if (bus.CellCount !== 32'd0 || bus.BitErrorCount !== 32'd0 || bus.SymbolErrorCount !== 32'd0 ||
          bus.FifoOverflow !== 1'b0 || bus.FifoUnderflow !== 1'b0 || bus.PageBitErrors !== 16'd0) begin
         n_bad++; $display("FAIL clear: got cells=%0d bits=%0d syms=%0d ovf=%b unf=%b pbe=%0d expected all 0",
                           bus.CellCount, bus.BitErrorCount, bus.SymbolErrorCount,
                           bus.FifoOverflow, bus.FifoUnderflow, bus.PageBitErrors);
      end
   endtask

   // Push on full with a simultaneous pop must be accepted.
   task automatic test_full_push_pop();
      while (wq.size() < DEPTH) step(1'b1, 2'(wq.size()), 1'b0, 16'h0, 1'b0);
      step(1'b1, 2'b01, 1'b1, 16'h3C00, 1'b0);
      n_cmp++;
      if (bus.FifoOverflow !== 1'b0) begin
         n_bad++; $display("FAIL full_push_pop: got ovf=%b expected 0", bus.FifoOverflow);
      end
      while (wq.size() > 0) step(1'b0, 2'b00, 1'b1, 16'h3266, 1'b0);
      idle(2);
   endtask

   task automatic test_back_to_back_random();
      logic [15:0] v;
      logic [15:0] thr [3];
      thr[0] = 16'h2333; thr[1] = 16'h2D9A; thr[2] = 16'h3733;
      do_clear();
      for (int i = 0; i < 400; i++) begin
         case ($urandom_range(0, 3))
            0:       v = thr[$urandom_range(0, 2)];
            1:       v = thr[$urandom_range(0, 2)] - 16'd1;
            default: v = 16'($urandom_range(0, 16'hFFFF));
         endcase
         if ($urandom_range(0, 49) == 0)
            step(1'b0, 2'b00, 1'b0, 16'h0, 1'b1);
         else
            step(($urandom_range(0, 99) < 55), 2'($urandom_range(0, 3)),
                 ($urandom_range(0, 99) < 50), v, 1'b0);
      end
      idle(2);
   endtask

   // Reset with a loaded FIFO: nothing queued survives.
   task automatic test_reset_midstream();
      while (wq.size() > 0) step(1'b0, 2'b00, 1'b1, 16'h119A, 1'b0);
      do_clear();
      for (int i = 0; i < 10; i++) step(1'b1, 2'b11, 1'b0, 16'h0, 1'b0);
      step(1'b0, 2'b00, 1'b1, 16'h119A, 1'b0);
      apply_reset();
      check_outputs_zero("midstream_reset");
      idle(3);
      step(1'b0, 2'b00, 1'b1, 16'h119A, 1'b0);
      n_cmp++;
      if (bus.FifoUnderflow !== 1'b1) begin
         n_bad++; $display("FAIL midstream_fifo_empty: got unf=%b expected 1", bus.FifoUnderflow);
      end
      idle(2);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_boundary();
      test_errors();
      test_page();
      test_overflow_underflow();
      test_full_push_pop();
      test_back_to_back_random();
      test_reset_midstream();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/channel_read_detector.md
# channel_read_detector

Read-side counterpart of the flash channel model. It receives the serial post-retention threshold-voltage stream, hard-detects each cell's 2-bit level against three read-reference voltages, and compares the result with the level originally written into the channel. Written levels are held in an internal FIFO to absorb the long program→RTN→CCI→retention latency. It accumulates bit, symbol and per-page error statistics for BER measurement.

## Interface
- FIFO_DEPTH, 64, written-level FIFO entries (power of 2)
- PAGE_CELLS, 16, cells per page for page statistics (matches word-line width)
- THR1, 16'h2333, read reference 1 (2.20 V)
- THR2, 16'h2D9A, read reference 2 (2.85 V)
- THR3, 16'h3733, read reference 3 (3.45 V)
- clk  in  1  clock, all logic rising-edge
- reset  in  1  asynchronous, active-high
- WriteValid  in  1  a level entered the channel this cycle
- WriteLevel  in  2  written level (Gray code, same encoding as channel input)
- ReadValid  in  1  retention output valid (driven by retention done flag)
- ReadVoltage  in  16  post-retention Vth, unsigned Q4.12 volts
- Clear  in  1  synchronous clear of statistics and sticky flags
- DetectedValid  out  1  DetectedLevel valid
- DetectedLevel  out  2  hard-decision level
- CellCount  out  32  compared cells
- BitErrorCount  out  32  accumulated bit errors
- SymbolErrorCount  out  32  accumulated cell errors
- PageDone  out  1  one-cycle pulse at page completion
- PageBitErrors  out  16  bit errors of last completed page
- FifoOverflow  out  1  sticky: write dropped on full FIFO
- FifoUnderflow  out  1  sticky: read arrived with FIFO empty

## Operation
- Detection: index 0 if V < THR1, 1 if V < THR2, 2 if V < THR3, else 3. Equality goes to the higher index. Gray map: index 0→2'b11, 1→2'b10, 2→2'b00, 3→2'b01.
- FIFO push: on WriteValid when not full. When full, the write is dropped and FifoOverflow is set. Pop happens on ReadValid when not empty.
- Simultaneous push and pop on a full FIFO: the pop frees a slot, so the write is accepted.
- Simultaneous push and pop on an empty FIFO: no bypass. The read counts as underflow and the write is stored.
- Underflow read: DetectedLevel is still produced. The cell is not counted and FifoUnderflow is set.
- Compare: bit errors = popcount(DetectedLevel ^ ref), range 0–2. Symbol error = (xor != 0).
- Counters saturate at all-ones and never wrap.
- Page: an internal counter over counted cells, 0..PAGE_CELLS-1, accumulates page bit errors. On the last cell of a page:
  - PageDone pulses.
  - PageBitErrors is latched to the page total including that cell.
  - The accumulator and the cell counter restart from 0.
- Clear:
  - Zeroes CellCount, BitErrorCount, SymbolErrorCount, PageBitErrors, the page counter/accumulator and both sticky flags.
  - Does not touch FIFO contents.
  - The stage-2 update in the same cycle is discarded; Clear wins.
- Reset: empties the FIFO, and every output goes to 0. Reset mid-stream discards in-flight pipeline stages.

## Timing
- 2-stage pipeline.
- ReadValid at cycle N → DetectedValid/DetectedLevel registered at N+1. The popped reference and the underflow tag are registered alongside.
- Counters, PageDone and PageBitErrors are updated at N+2.
- Sticky flags are set at N+1.
- Back-to-back ReadValid every cycle is supported with no stall, at full throughput.
- A WriteValid at cycle M is visible to a ReadValid at cycle M+1 or later.

## Structure
- Package channel_read_pkg holds:
  - VOLT_W=16 and the Q4.12 format note.
  - Default threshold constants.
  - The Gray-mapping function and the 2-bit popcount function.
- Sub-module level_ref_fifo: synchronous FIFO (DEPTH, WIDTH=2) with full/empty, using read-before-write semantics as specified above.
- Top module: detector, comparison pipeline, counters and page logic.

## Test plan
- Reset → all outputs 0. Assert reset mid-stream with 10 entries queued → FIFO empty; no DetectedValid after release.
- Write 11,10,00,01, then read 0x119A, 0x28CD, 0x3266, 0x3C00 → DetectedLevel 11,10,00,01; CellCount=4; BitErrorCount=0; DetectedValid 1 cycle after each ReadValid.
- Boundary: write 11 / read 0x2333 → detected 10, bit+1, symbol+1. Write 11 / read 0x2332 → detected 11, no error.
- Write 01 / read 0x119A → detected 11, 1 bit error. Write 10 / read 0x3C00 → detected 01, 2 bit errors. Totals: Bit=3, Symbol=2.
- 16 counted cells with 3 single-bit errors → PageDone pulse exactly 2 cycles after the 16th ReadValid; PageBitErrors=3; the next page restarts the accumulation.
- 65 writes with no reads → FifoOverflow=1 and the 65th write is dropped. Then 65 reads → the 65th sets FifoUnderflow and CellCount=64. Clear → counters and flags 0.
